// File: rtl/havalimani_kapi_boru.sv
// Airport gate pipeline: registers passenger, computes excess-baggage fee, decides boarding.
// Latency 3 edges from accept to result; throughput 1 passenger/cycle.
// Backpressure: a held result (cikis_gecerli && !cikis_hazir) freezes all stages and drops giris_hazir.
module havalimani_kapi_boru #(
  parameter int BIT           = 6,
  parameter int AW            = 6,
  parameter int BW            = 9,
  parameter int LIMIT         = 10,
  parameter int UCRET_YERLI   = 3,
  parameter int UCRET_YABANCI = 6,
  parameter int MAX_AGIRLIK   = 40,
  parameter int SW            = 8
) (
  input  logic           saat,
  input  logic           reset,
  input  logic           giris_gecerli,
  output logic           giris_hazir,
  input  logic [BIT-1:0] kimlik_no,
  input  logic           uyruk,
  input  logic [AW-1:0]  agirlik,
  input  logic [BW-1:0]  bakiye,
  output logic           cikis_gecerli,
  input  logic           cikis_hazir,
  output logic           kalkis,
  output logic [BW-1:0]  k_bakiye,
  output logic [1:0]     red_kodu,
  output logic [SW-1:0]  onay_sayisi,
  output logic [SW-1:0]  red_sayisi
);

  localparam int UMAX = (UCRET_YABANCI > UCRET_YERLI) ? UCRET_YABANCI : UCRET_YERLI;
  localparam int FW   = $clog2(UMAX + 1);
  localparam int UW   = AW + FW;
  localparam int CW   = ((UW > BW) ? UW : BW) + 1;

  localparam logic [AW-1:0] LIM     = AW'(LIMIT);
  localparam logic [AW-1:0] MAXA    = AW'(MAX_AGIRLIK);
  localparam logic [FW-1:0] R_YERLI = FW'(UCRET_YERLI);
  localparam logic [FW-1:0] R_YAB   = FW'(UCRET_YABANCI);

  typedef struct packed {
    logic [BIT-1:0] kimlik;
    logic           uyruk;
    logic [AW-1:0]  agirlik;
    logic [BW-1:0]  bakiye;
  } yolcu_t;

  typedef struct packed {
    yolcu_t        yolcu;
    logic [UW-1:0] ucret;
  } ucretli_t;

  logic     ilerle;
  logic     s1_vld, s2_vld;
  yolcu_t   s1_dat;
  ucretli_t s2_dat;

  logic [AW-1:0] fazla;
  logic [FW-1:0] oran;
  logic [UW-1:0] ucret;

  logic [1:0]    kod;
  logic          kalkis_d;
  logic [BW-1:0] k_bakiye_d;
  logic [1:0]    red_kodu_d;

  assign ilerle      = !(cikis_gecerli && !cikis_hazir);
  assign giris_hazir = ilerle;

  always_comb begin
    fazla = (s1_dat.agirlik > LIM) ? (s1_dat.agirlik - LIM) : '0;
    oran  = s1_dat.uyruk ? R_YAB : R_YERLI;
    ucret = UW'(fazla) * UW'(oran);
  end

  // Blacklist beats overweight beats insufficient balance.
  always_comb begin
    kod = 2'b00;
    if ((s2_dat.yolcu.kimlik == '0) || (s2_dat.yolcu.kimlik == '1))
      kod = 2'b10;
    else if (s2_dat.yolcu.agirlik > MAXA)
      kod = 2'b11;
    else if (CW'(s2_dat.ucret) > CW'(s2_dat.yolcu.bakiye))
      kod = 2'b01;

    kalkis_d   = 1'b0;
    k_bakiye_d = '0;
    red_kodu_d = 2'b00;
    if (s2_vld) begin
      red_kodu_d = kod;
      kalkis_d   = (kod == 2'b00);
      k_bakiye_d = (kod == 2'b00) ? (s2_dat.yolcu.bakiye - BW'(s2_dat.ucret))
                                  : s2_dat.yolcu.bakiye;
    end
  end

  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      s1_vld        <= 1'b0;
      s1_dat        <= '0;
      s2_vld        <= 1'b0;
      s2_dat        <= '0;
      cikis_gecerli <= 1'b0;
      kalkis        <= 1'b0;
      k_bakiye      <= '0;
      red_kodu      <= 2'b00;
    end else if (ilerle) begin
      s1_vld        <= giris_gecerli;
      s1_dat        <= '{kimlik: kimlik_no, uyruk: uyruk, agirlik: agirlik, bakiye: bakiye};
      s2_vld        <= s1_vld;
      s2_dat        <= '{yolcu: s1_dat, ucret: ucret};
      cikis_gecerli <= s2_vld;
      kalkis        <= kalkis_d;
      k_bakiye      <= k_bakiye_d;
      red_kodu      <= red_kodu_d;
    end
  end

  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      onay_sayisi <= '0;
      red_sayisi  <= '0;
    end else if (cikis_gecerli && cikis_hazir) begin
      if (kalkis) begin
        if (onay_sayisi != '1) onay_sayisi <= onay_sayisi + SW'(1);
      end else begin
        if (red_sayisi != '1) red_sayisi <= red_sayisi + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_havalimani_kapi_boru.sv
// Scoreboard bench for havalimani_kapi_boru: model results queued at input handshake, popped at output handshake.
module tb_havalimani_kapi_boru;

  localparam int BIT = 6, AW = 6, BW = 9, SW = 8;
  localparam int LIMIT = 10, U_YER = 3, U_YAB = 6, MAXA = 40;

  logic           saat = 1'b0;
  logic           reset = 1'b0;
  logic           giris_gecerli = 1'b0;
  logic           giris_hazir;
  logic [BIT-1:0] kimlik_no = '0;
  logic           uyruk = 1'b0;
  logic [AW-1:0]  agirlik = '0;
  logic [BW-1:0]  bakiye = '0;
  logic           cikis_gecerli;
  logic           cikis_hazir = 1'b1;
  logic           kalkis;
  logic [BW-1:0]  k_bakiye;
  logic [1:0]     red_kodu;
  logic [SW-1:0]  onay_sayisi, red_sayisi;

  always #5 saat = ~saat;

  havalimani_kapi_boru dut (
    .saat(saat), .reset(reset),
    .giris_gecerli(giris_gecerli), .giris_hazir(giris_hazir),
    .kimlik_no(kimlik_no), .uyruk(uyruk), .agirlik(agirlik), .bakiye(bakiye),
    .cikis_gecerli(cikis_gecerli), .cikis_hazir(cikis_hazir),
    .kalkis(kalkis), .k_bakiye(k_bakiye), .red_kodu(red_kodu),
    .onay_sayisi(onay_sayisi), .red_sayisi(red_sayisi)
  );

  typedef struct {
    int kalkis;
    int kb;
    int kod;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_err = 0;
  int m_onay = 0, m_red = 0;
  int acc_cnt = 0;

  function automatic exp_t model(int kim, int uy, int ag, int bk);
    exp_t e;
    int fazla, fee;
    fazla = (ag > LIMIT) ? ag - LIMIT : 0;
    fee   = fazla * ((uy != 0) ? U_YAB : U_YER);
    if (kim == 0 || kim == (1 << BIT) - 1) e.kod = 2;
    else if (ag > MAXA)                    e.kod = 3;
    else if (fee > bk)                     e.kod = 1;
    else                                   e.kod = 0;
    e.kalkis = (e.kod == 0) ? 1 : 0;
    e.kb     = (e.kod == 0) ? bk - fee : bk;
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge saat) begin
    if (reset && giris_gecerli && giris_hazir) begin
      q.push_back(model(int'(kimlik_no), int'(uyruk), int'(agirlik), int'(bakiye)));
      acc_cnt++;
    end
  end

  always @(posedge saat) begin : pop_blk
    exp_t e;
    if (reset && cikis_gecerli && cikis_hazir && q.size() > 0) begin
      e = q.pop_front();
      if (e.kalkis != 0) begin
        if (m_onay < (1 << SW) - 1) m_onay++;
      end else begin
        if (m_red < (1 << SW) - 1) m_red++;
      end
    end
  end

  always @(negedge saat) begin
    if (reset) begin
      if (cikis_gecerli) begin
        chk("result_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          chk("kalkis", int'(kalkis), q[0].kalkis);
          chk("k_bakiye", int'(k_bakiye), q[0].kb);
          chk("red_kodu", int'(red_kodu), q[0].kod);
        end
      end else begin
        chk("idle_outputs_zero", int'({kalkis, k_bakiye, red_kodu}), 0);
      end
      chk("onay_sayisi", int'(onay_sayisi), m_onay);
      chk("red_sayisi", int'(red_sayisi), m_red);
    end
  end

  task automatic send(int kim, int uy, int ag, int bk);
    int ok;
    @(negedge saat);
    kimlik_no = BIT'(kim); uyruk = uy[0]; agirlik = AW'(ag); bakiye = BW'(bk);
    giris_gecerli = 1'b1;
    ok = 0;
    for (int i = 0; i < 100 && ok == 0; i++) begin
      @(posedge saat);
      if (giris_hazir) ok = 1;
    end
    chk("send_accepted", ok, 1);
    @(negedge saat);
    giris_gecerli = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge saat);
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic rand_inputs();
    kimlik_no = ($urandom % 8 == 0) ? (($urandom % 2 == 0) ? '0 : '1) : BIT'($urandom);
    uyruk     = 1'($urandom);
    agirlik   = AW'($urandom);
    bakiye    = BW'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_giris_hazir", int'(giris_hazir), 1);
    chk("rst_cikis_gecerli", int'(cikis_gecerli), 0);
    chk("rst_counters", int'(onay_sayisi) + int'(red_sayisi), 0);
    repeat (2) @(negedge saat);
    reset = 1'b1;

    // Basic approval with explicit 3-edge latency
    @(negedge saat);
    kimlik_no = 6'b000111; uyruk = 1'b0; agirlik = 6'd11; bakiye = 9'd500;
    giris_gecerli = 1'b1;
    @(posedge saat);
    @(negedge saat);
    giris_gecerli = 1'b0;
    @(posedge saat); @(negedge saat);
    chk("lat_edge2_not_valid", int'(cikis_gecerli), 0);
    @(posedge saat); @(negedge saat);
    chk("lat_edge3_valid", int'(cikis_gecerli), 1);
    chk("req041_kalkis", int'(kalkis), 1);
    chk("req041_k_bakiye", int'(k_bakiye), 497);
    chk("req041_red_kodu", int'(red_kodu), 0);
    @(posedge saat); @(negedge saat);
    chk("req041_onay", int'(onay_sayisi), 1);

    send(7, 1, 14, 20);
    send(7, 1, 14, 24);
    send(63, 0, 49, 100);
    send(0, 0, 49, 100);
    send(32, 0, 49, 100);
    drain();
    chk("directed_onay", int'(onay_sayisi), 2);
    chk("directed_red", int'(red_sayisi), 4);

    // Stall: five back-to-back offers into a blocked output
    cikis_hazir = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge saat);
      kimlik_no = BIT'(5 + i); uyruk = 1'(i); agirlik = AW'(8 + 4 * i); bakiye = 9'd300;
      giris_gecerli = 1'b1;
    end
    @(negedge saat);
    giris_gecerli = 1'b0;
    chk("stall_accepted", acc_cnt, 3);
    chk("stall_giris_hazir", int'(giris_hazir), 0);
    repeat (4) @(negedge saat);
    chk("stall_counters_frozen", int'(onay_sayisi) + int'(red_sayisi), 6);
    cikis_hazir = 1'b1;
    drain();
    chk("stall_counters_advance", int'(onay_sayisi) + int'(red_sayisi), 9);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 1500; i++) begin
      @(negedge saat);
      rand_inputs();
      giris_gecerli = ($urandom % 4 != 0);
      cikis_hazir   = ($urandom % 4 != 0);
    end
    @(negedge saat);
    giris_gecerli = 1'b0;
    cikis_hazir   = 1'b1;
    drain();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 20; i++) begin
      @(negedge saat);
      rand_inputs();
      giris_gecerli = 1'b1;
    end
    #3;
    reset = 1'b0;
    q.delete();
    m_onay = 0;
    m_red  = 0;
    #1;
    chk("arst_cikis_gecerli", int'(cikis_gecerli), 0);
    chk("arst_outputs", int'({kalkis, k_bakiye, red_kodu}), 0);
    chk("arst_onay", int'(onay_sayisi), 0);
    chk("arst_red", int'(red_sayisi), 0);
    chk("arst_giris_hazir", int'(giris_hazir), 1);
    repeat (2) @(negedge saat);
    giris_gecerli = 1'b0;
    #2;
    reset = 1'b1;
    send(9, 0, 10, 5);
    drain();
    chk("post_reset_onay", int'(onay_sayisi), 1);
    chk("post_reset_red", int'(red_sayisi), 0);

    // Counter saturation
    @(negedge saat);
    kimlik_no = 6'd7; uyruk = 1'b0; agirlik = 6'd5; bakiye = 9'd100;
    giris_gecerli = 1'b1;
    repeat (260) @(negedge saat);
    giris_gecerli = 1'b0;
    drain();
    chk("onay_saturated", int'(onay_sayisi), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
